mux64_burst_arbiter: RTL and testbench

- Shares the ALU's 64-bit 2:1 select mux between two requesters (channel 0, channel 1).
- Round-robin arbitration with optional burst hold.
- Drives the mux select line and registers the selected word into one output stage with valid/ready handshake.
- Sits between the two 64-bit producers and the downstream 64-bit consumer.

---
 rtl/mux64_burst_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mux64_burst_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux64_burst_arbiter.sv
// ---------------------------------------------------------------------------
// mux64_burst_arbiter
//
// Shares a 64-bit 2:1 select mux between two producers (channel 0 and
// channel 1). Arbitration is round robin with an optional burst hold of up to
// MAX_BURST consecutive beats. The selected word is registered into a single
// valid/ready output stage.
//
// Optional feature macro: ARB_PERF_CNT_EN
//   defined   -> beats0/beats1 count accepted beats per channel (32-bit, wrap)
//   undefined -> beats0/beats1 are tied to zero and no counter flops exist
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   in0_valid/ready/data channel 0 producer handshake and 64-bit word
//   in1_valid/ready/data channel 1 producer handshake and 64-bit word
//   mux_sel             mux select; 1 picks channel 0, 0 picks channel 1
//   out_valid/ready/data registered output stage towards the consumer
//   out_src             channel that produced out_data
//   beats0/beats1       per-channel accepted-beat counters (optional)
// ---------------------------------------------------------------------------
module mux64_burst_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [63:0] in0_data,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [63:0] in1_data,
  output logic        mux_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_src,
  output logic [31:0] beats0,
  output logic [31:0] beats1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last;
  logic               w_last_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               r_out_valid;
  logic [63:0]        r_out_data;
  logic               r_out_src;

  logic               w_load_en;
  logic               w_gnt;
  logic               w_xfer0;
  logic               w_xfer1;
  logic               w_xfer;
  logic               w_hold_valid;
  logic [63:0]        w_mux_data;

  // The output stage can take a new word when empty or being drained now.
  assign w_load_en = ~r_out_valid | out_ready;

  // Grant: a hold state pins the channel; in IDLE a lone requester wins,
  // otherwise the channel not served last is preferred.
  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt = ~r_last;
    case (r_state)
      HOLD0:   w_gnt = 1'b0;
      HOLD1:   w_gnt = 1'b1;
      default: begin
        if (in0_valid && !in1_valid)      w_gnt = 1'b0;
        else if (in1_valid && !in0_valid) w_gnt = 1'b1;
        else                              w_gnt = ~r_last;
      end
    endcase
  end

  assign mux_sel    = ~w_gnt;
  assign in0_ready  = w_load_en & ~w_gnt;
  assign in1_ready  = w_load_en &  w_gnt;
  assign w_xfer0    = in0_valid & in0_ready;
  assign w_xfer1    = in1_valid & in1_ready;
  assign w_xfer     = w_xfer0 | w_xfer1;
  assign w_mux_data = mux_sel ? in0_data : in1_data;
  assign w_cnt_inc  = r_cnt + 1'b1;

  // Valid of the channel currently holding the burst.
  assign w_hold_valid = w_gnt ? in1_valid : in0_valid;

  // Next-state logic for burst tracking.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (MAX_BURST > 1) begin
            w_state_nxt = w_gnt ? HOLD1 : HOLD0;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_last_nxt  = w_gnt;
          end
        end
      end
      HOLD0, HOLD1: begin
        if (w_xfer) begin
          if (w_cnt_inc == CNT_W'(MAX_BURST)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = w_gnt;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end else if (!w_hold_valid) begin
          // Holder went quiet: end the burst so the other channel wins next.
          w_state_nxt = IDLE;
          w_last_nxt  = w_gnt;
          w_cnt_nxt   = '0;
        end
        // Valid but backpressured: state and count hold.
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output stage: input data is captured only on a transfer, so
  // backpressure can neither drop nor duplicate a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_src   <= w_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_beats0;
  logic [31:0] r_beats1;

  // Free-running beat counters; wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beats0 <= '0;
      r_beats1 <= '0;
    end else begin
      if (w_xfer0) r_beats0 <= r_beats0 + 32'd1;
      if (w_xfer1) r_beats1 <= r_beats1 + 32'd1;
    end
  end

  assign beats0 = r_beats0;
  assign beats1 = r_beats1;
`else
  assign beats0 = '0;
  assign beats1 = '0;
`endif

endmodule

// File: tb/tb_mux64_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux64_burst_arbiter
//
// Directed bench for mux64_burst_arbiter. Instance dut uses MAX_BURST=4,
// instance dut_rr uses MAX_BURST=1. Inputs change on the falling edge and
// outputs are checked on the falling edge (or 1 ns after an input change for
// combinational outputs).
// ---------------------------------------------------------------------------
module tb_mux64_burst_arbiter;

  localparam logic [63:0] A_BASE = 64'hA000_0000_0000_0000;
  localparam logic [63:0] B_BASE = 64'hB000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in1_valid, out_ready;
  logic [63:0] in0_data, in1_data;
  logic        in0_ready, in1_ready, mux_sel, out_valid, out_src;
  logic [63:0] out_data;
  logic [31:0] beats0, beats1;

  logic        rr_in0_valid, rr_in1_valid;
  logic [63:0] rr_in0_data, rr_in1_data;
  logic        rr_in0_ready, rr_in1_ready, rr_mux_sel, rr_out_valid, rr_out_src;
  logic [63:0] rr_out_data;
  logic [31:0] rr_beats0, rr_beats1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux64_burst_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .mux_sel(mux_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .beats0(beats0), .beats1(beats1)
  );

  mux64_burst_arbiter #(.MAX_BURST(1), .CNT_W(8)) dut_rr (
    .clk(clk), .rst(rst),
    .in0_valid(rr_in0_valid), .in0_ready(rr_in0_ready), .in0_data(rr_in0_data),
    .in1_valid(rr_in1_valid), .in1_ready(rr_in1_ready), .in1_data(rr_in1_data),
    .mux_sel(rr_mux_sel), .out_valid(rr_out_valid), .out_ready(out_ready),
    .out_data(rr_out_data), .out_src(rr_out_src), .beats0(rr_beats0),
    .beats1(rr_beats1)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat on dut expected from channel e_src: checks the ready pattern
  // before the edge, then the registered word after it.
  task automatic step_expect(input string tag, input bit e_src);
    logic [63:0] e_data;
    e_data = e_src ? in1_data : in0_data;
    #1;
    check({tag, "_rdy0"}, {63'd0, in0_ready}, {63'd0, !e_src});
    check({tag, "_rdy1"}, {63'd0, in1_ready}, {63'd0, e_src});
    @(negedge clk);
    check({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_src"}, {63'd0, out_src}, {63'd0, e_src});
    check({tag, "_data"}, out_data, e_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  bit exp_burst [0:9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    in0_valid = 0; in1_valid = 0; out_ready = 1;
    in0_data = '0; in1_data = '0;
    rr_in0_valid = 0; rr_in1_valid = 0;
    rr_in0_data = '0; rr_in1_data = '0;

    // Reset then idle.
    do_reset();
    #1;
    check("rst_mux_sel", {63'd0, mux_sel}, 64'd1);
    check("rst_rdy0", {63'd0, in0_ready}, 64'd1);
    check("rst_rdy1", {63'd0, in1_ready}, 64'd0);
    check("rst_vld", {63'd0, out_valid}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_beats0", {32'd0, beats0}, 64'd0);

    // Burst and fairness: 4 beats ch0, 4 beats ch1, then ch0 again.
    in0_valid = 1; in1_valid = 1;
    for (int k = 0; k < 10; k++) begin
      in0_data = A_BASE + 64'(k);
      in1_data = B_BASE + 64'(k);
      step_expect($sformatf("burst%0d", k), exp_burst[k]);
    end

    // Now in HOLD0 with cnt=2: backpressure for 3 cycles.
    out_ready = 0;
    in0_data  = 64'hDEAD_BEEF_0000_0000;
    in1_data  = 64'hDEAD_BEEF_1111_1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_rdy0", k), {63'd0, in0_ready}, 64'd0);
      check($sformatf("bp%0d_rdy1", k), {63'd0, in1_ready}, 64'd0);
      @(negedge clk);
      check($sformatf("bp%0d_vld", k), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp%0d_data", k), out_data, A_BASE + 64'd9);
    end

    // Release: two more ch0 beats finish the burst, then ch1 is granted.
    out_ready = 1;
    in0_data = A_BASE + 64'd20; in1_data = B_BASE + 64'd20;
    step_expect("rel0", 1'b0);
    in0_data = A_BASE + 64'd21; in1_data = B_BASE + 64'd21;
    step_expect("rel1", 1'b0);
    in0_data = A_BASE + 64'd22; in1_data = B_BASE + 64'd22;
    step_expect("rel2", 1'b1);

    // Reset while in HOLD1 with out_valid=1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in0_valid = 0; in1_valid = 0;
    #1;
    check("hrst_vld", {63'd0, out_valid}, 64'd0);
    check("hrst_mux_sel", {63'd0, mux_sel}, 64'd1);
    check("hrst_data", out_data, 64'd0);

    // Early release: ch0 drops after two beats, ch1 wins the next cycle.
    in0_valid = 1; in1_valid = 1;
    in0_data = A_BASE + 64'd30; in1_data = B_BASE + 64'd30;
    step_expect("early0", 1'b0);
    in0_data = A_BASE + 64'd31; in1_data = B_BASE + 64'd31;
    step_expect("early1", 1'b0);
    in0_valid = 0;
    in1_data  = B_BASE + 64'd32;
    @(negedge clk);
    check("early_gap_vld", {63'd0, out_valid}, 64'd0);
    check("early_gap_mux_sel", {63'd0, mux_sel}, 64'd0);
    step_expect("early2", 1'b1);

    // Counters: 10 ch0 beats, one gap cycle, 6 ch1 beats.
    do_reset();
    in0_valid = 1; in1_valid = 0;
    for (int k = 0; k < 10; k++) begin
      in0_data = A_BASE + 64'(40 + k);
      step_expect($sformatf("cnt0_%0d", k), 1'b0);
    end
    in0_valid = 0; in1_valid = 1;
    @(negedge clk);
    check("cnt_gap_vld", {63'd0, out_valid}, 64'd0);
    for (int k = 0; k < 6; k++) begin
      in1_data = B_BASE + 64'(60 + k);
      step_expect($sformatf("cnt1_%0d", k), 1'b1);
    end
`ifdef ARB_PERF_CNT_EN
    check("beats0_10", {32'd0, beats0}, 64'd10);
    check("beats1_6", {32'd0, beats1}, 64'd6);
`else
    check("beats0_off", {32'd0, beats0}, 64'd0);
    check("beats1_off", {32'd0, beats1}, 64'd0);
`endif

    // Wrap: preload beats0 during the gap cycle, then one ch0 beat.
    in1_valid = 0; in0_valid = 1;
`ifdef ARB_PERF_CNT_EN
    force dut.r_beats0 = 32'hFFFF_FFFF;
    #1;
    release dut.r_beats0;
`endif
    @(negedge clk);
    in0_data = A_BASE + 64'd70;
    step_expect("wrap", 1'b0);
`ifdef ARB_PERF_CNT_EN
    check("beats0_wrap", {32'd0, beats0}, 64'd0);
    check("beats1_keep", {32'd0, beats1}, 64'd6);
`else
    check("beats0_wrap_off", {32'd0, beats0}, 64'd0);
`endif
    in0_valid = 0;

    // Pure round robin on the MAX_BURST=1 instance: 0,1,0,1.
    out_ready = 1;
    rr_in0_valid = 1; rr_in1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      rr_in0_data = A_BASE + 64'(80 + k);
      rr_in1_data = B_BASE + 64'(80 + k);
      @(negedge clk);
      check($sformatf("rr%0d_vld", k), {63'd0, rr_out_valid}, 64'd1);
      check($sformatf("rr%0d_src", k), {63'd0, rr_out_src}, {63'd0, k[0]});
      check($sformatf("rr%0d_data", k), rr_out_data,
            k[0] ? (B_BASE + 64'(80 + k)) : (A_BASE + 64'(80 + k)));
    end
    rr_in0_valid = 0; rr_in1_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
